// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a single-port, registered-read instruction ROM.
// Port A has fixed priority; define ROM_ARB_STARVE_GUARD_EN to bound port B's wait.
module rom_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
`ifdef ROM_ARB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT   = 4
`endif
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_A,
    input  logic [ADDR_WIDTH-1:0] ADDR_A,
    output logic                  ACK_A,
    output logic                  VALID_A,
    output logic [DATA_WIDTH-1:0] DATA_A,
    input  logic                  REQ_B,
    input  logic [ADDR_WIDTH-1:0] ADDR_B,
    output logic                  ACK_B,
    output logic                  VALID_B,
    output logic [DATA_WIDTH-1:0] DATA_B,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_DATA
);
    // vld_pipe[0] rides with ROM_ADDR, vld_pipe[STAGES] with ROM_DATA.
    localparam int STAGES = 1;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] port_pipe;   // 1 = read belongs to port B
    logic            b_prio;
    logic            ret_a;
    logic            ret_b;

`ifdef ROM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

    logic [2:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (RESET)
            wait_cnt <= '0;
        else if (!REQ_B || ACK_B)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + 3'd1;
    end

    assign b_prio = (wait_cnt == WAIT_MAX);
`else
    assign b_prio = 1'b0;
`endif

    assign ACK_A = !RESET && REQ_A && !(REQ_B && b_prio);
    assign ACK_B = !RESET && REQ_B && (!REQ_A || b_prio);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_pipe  <= '0;
            port_pipe <= '0;
            ROM_ADDR  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], ACK_A | ACK_B};
            port_pipe <= {port_pipe[STAGES-1:0], ACK_B};
            if (ACK_B)
                ROM_ADDR <= ADDR_B;
            else if (ACK_A)
                ROM_ADDR <= ADDR_A;
        end
    end

    assign ret_a = vld_pipe[STAGES] && !port_pipe[STAGES];
    assign ret_b = vld_pipe[STAGES] &&  port_pipe[STAGES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            VALID_A <= 1'b0;
            VALID_B <= 1'b0;
            DATA_A  <= '0;
            DATA_B  <= '0;
        end else begin
            VALID_A <= ret_a;
            VALID_B <= ret_b;
            if (ret_a)
                DATA_A <= ROM_DATA;
            if (ret_b)
                DATA_B <= ROM_DATA;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: directed steps then random traffic, scored against
// a queue-based model of arbitration and 3-cycle read returns.
module tb_rom_port_arbiter;
    localparam int MW = 4;
`ifdef ROM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ_A, REQ_B;
    logic [7:0] ADDR_A, ADDR_B;
    logic       ACK_A, ACK_B, VALID_A, VALID_B;
    logic [7:0] DATA_A, DATA_B, ROM_ADDR, ROM_DATA;

    always #5 CLK = ~CLK;

    rom_port_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_A(REQ_A), .ADDR_A(ADDR_A), .ACK_A(ACK_A), .VALID_A(VALID_A), .DATA_A(DATA_A),
        .REQ_B(REQ_B), .ADDR_B(ADDR_B), .ACK_B(ACK_B), .VALID_B(VALID_B), .DATA_B(DATA_B),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA)
    );

    logic [7:0] rom [256];
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         due;
    } ret_t;

    ret_t       pend[$];
    int         cyc, errs, checks, refused, nb_seen, va_seen;
    logic [7:0] m_addr, m_da, m_db;
    logic       ea, eb, acc_a, acc_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs at negedge, then advance the model at posedge.
    task automatic step();
        logic va, vb;
        ret_t r;
        @(negedge CLK);
        if (RESET) begin
            ea = 1'b0;
            eb = 1'b0;
        end else begin
            eb = REQ_B && (!REQ_A || (GUARD && refused >= MW));
            ea = REQ_A && !eb;
        end
        chk("ack_a", ACK_A, ea);
        chk("ack_b", ACK_B, eb);
        chk("rom_addr", ROM_ADDR, m_addr);
        va = 1'b0;
        vb = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            if (pend[0].port) begin vb = 1'b1; m_db = pend[0].data; end
            else              begin va = 1'b1; m_da = pend[0].data; end
            void'(pend.pop_front());
        end
        chk("valid_a", VALID_A, va);
        chk("valid_b", VALID_B, vb);
        chk("data_a", DATA_A, m_da);
        chk("data_b", DATA_B, m_db);
        if (ACK_B === 1'b1) nb_seen++;
        if (VALID_A === 1'b1) va_seen++;
        @(posedge CLK);
        if (RESET) begin
            pend.delete();
            m_addr  = 8'h00;
            m_da    = 8'h00;
            m_db    = 8'h00;
            refused = 0;
        end else begin
            if (ea || eb) begin
                m_addr = eb ? ADDR_B : ADDR_A;
                r.port = eb;
                r.data = rom[m_addr];
                r.due  = cyc + 3;
                pend.push_back(r);
            end
            refused = (!REQ_B || eb) ? 0 : ((refused < MW) ? refused + 1 : MW);
        end
        acc_a = ea;
        acc_b = eb;
        cyc++;
        #1;
    endtask

    initial begin
        errs = 0; checks = 0; cyc = 0; refused = 0; nb_seen = 0; va_seen = 0;
        m_addr = 8'h00; m_da = 8'h00; m_db = 8'h00; acc_a = 1'b0; acc_b = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h10] = 8'h5A;
        rom[8'h20] = 8'hC3;
        RESET = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; ADDR_A = 8'h00; ADDR_B = 8'h00;
        @(posedge CLK); #1;

        // Reset held with both requesting: no acks, outputs at zero.
        REQ_A = 1'b1; REQ_B = 1'b1;
        step(); step();

        // Single A read of 0x10; first ack right after release.
        RESET = 1'b0; REQ_B = 1'b0; ADDR_A = 8'h10;
        step();
        REQ_A = 1'b0;
        step(); step(); step();
        chk("single_data_a", DATA_A, 8'h5A);

        // Back-to-back A reads 0..3.
        for (int i = 0; i < 4; i++) begin
            REQ_A = 1'b1; ADDR_A = 8'(i);
            step();
        end
        REQ_A = 1'b0;
        va_seen = 0;
        step(); step(); step(); step();
        chk("pipe_valid_a_count", va_seen, 3);

        // Contention: A and B both requesting for 10 cycles.
        nb_seen = 0;
        REQ_A = 1'b1; REQ_B = 1'b1; ADDR_A = 8'h40; ADDR_B = 8'h80;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc_a) ADDR_A = ADDR_A + 8'h01;
        end
        chk("contend_b_grants", nb_seen, GUARD ? 2 : 0);
        REQ_A = 1'b0;
        step();
        REQ_B = 1'b0;
        step(); step(); step(); step();

        // B read at the top address.
        REQ_B = 1'b1; ADDR_B = 8'hFF;
        step();
        REQ_B = 1'b0;
        step(); step(); step();
        chk("addr_ff_data_b", DATA_B, rom[8'hFF]);

        // Reset with two A reads in flight: neither returns.
        REQ_A = 1'b1; ADDR_A = 8'h30;
        step();
        ADDR_A = 8'h31;
        step();
        REQ_A = 1'b0; RESET = 1'b1;
        va_seen = 0;
        step();
        RESET = 1'b0;
        step(); step(); step();
        chk("flushed_valid_a", va_seen, 0);
        REQ_A = 1'b1; ADDR_A = 8'h20;
        step();
        REQ_A = 1'b0;
        step(); step(); step();
        chk("post_reset_data_a", DATA_A, 8'hC3);

        // Random traffic; held requests keep their address until acked.
        for (int k = 0; k < 400; k++) begin
            RESET = ($urandom_range(0, 99) == 0);
            if (!REQ_A || acc_a) begin
                REQ_A  = ($urandom_range(0, 2) != 0);
                ADDR_A = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                REQ_A = 1'b0;
            end
            if (!REQ_B || acc_b) begin
                REQ_B  = ($urandom_range(0, 1) != 0);
                ADDR_B = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                REQ_B = 1'b0;
            end
            step();
        end
        RESET = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("drained", pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
